// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared encodings for the traffic-light controller and its
//             farm-road sensor front end.
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

  // Light encodings driven on the light_* buses
  localparam logic [2:0] C_LIGHT_G = 3'b001;
  localparam logic [2:0] C_LIGHT_Y = 3'b010;
  localparam logic [2:0] C_LIGHT_R = 3'b100;

  // Main controller state codes
  typedef enum logic [1:0] {
    CTRL_HWY_GREEN   = 2'd0,
    CTRL_HWY_YELLOW  = 2'd1,
    CTRL_FARM_GREEN  = 2'd2,
    CTRL_FARM_YELLOW = 2'd3
  } ctrl_state_t;

  // Vehicle qualification FSM states
  typedef enum logic [1:0] {
    Q_IDLE     = 2'd0,
    Q_QUALIFY  = 2'd1,
    Q_OCCUPIED = 2'd2
  } qual_state_t;

  // Default clk cycles per tick strobe
  localparam int C_DEFAULT_TICK_DIV = 4;

endpackage
`default_nettype wire

// File: rtl/sig_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : sig_debouncer
//  Purpose  : Synchronises an asynchronous level and accepts a new level only
//             after it has persisted for DEBOUNCE_TICKS consecutive ticks.
//  Revision : 1.0  initial release
// ============================================================================
module sig_debouncer #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sig_raw,
  output logic sig_db
);

  localparam int                C_DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [C_DB_W-1:0]      r_db_cnt;
  logic                   r_level;
  logic                   w_sig_s;

  assign w_sig_s = r_sync[SYNC_STAGES-1];
  assign sig_db  = r_level;

  // Synchroniser chain runs every clk, independent of the tick strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], sig_raw};
  end

  // Count consecutive disagreeing ticks; flip the level once the run is long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else if (tick) begin
      if (w_sig_s == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == C_DB_LAST) begin
        r_level  <= w_sig_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + C_DB_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/farm_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : farm_sensor_conditioner
//  Purpose  : Turns the raw farm-road loop detector into the clean car_req
//             the traffic controller samples: debounce, dwell qualification,
//             queued-vehicle count and request hold until farm green.
//  Revision : 1.0  initial release
// ============================================================================
module farm_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_TICKS  = 3,
  parameter int MIN_DWELL_TICKS = 2,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               loop_raw,
  input  logic               farm_green,
  output logic               present,
  output logic               vehicle_evt,
  output logic               car_req,
  output logic [COUNT_W-1:0] queue_cnt
);

  localparam int                 C_DW_W      = $clog2(MIN_DWELL_TICKS + 1);
  localparam logic [C_DW_W-1:0]  C_DWELL_LAST = C_DW_W'(MIN_DWELL_TICKS - 1);
  localparam logic [COUNT_W-1:0] C_CNT_MAX   = {COUNT_W{1'b1}};

  qual_state_t        r_state, w_state_next;
  logic [C_DW_W-1:0]  r_dwell, w_dwell_next;
  logic [COUNT_W-1:0] r_queue, w_queue_next;
  logic               r_car_req;
  logic               w_evt;
  logic               w_present;

  sig_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_debouncer (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .sig_raw (loop_raw),
    .sig_db  (w_present)
  );

  assign present     = w_present;
  assign vehicle_evt = w_evt;
  assign car_req     = r_car_req;
  assign queue_cnt   = r_queue;

  // Qualify FSM and dwell counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= Q_IDLE;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_next;
      r_dwell <= w_dwell_next;
    end
  end

  // Next state: a vehicle qualifies once the loop stays present for the full dwell
  always_comb begin
    w_state_next = r_state;
    w_dwell_next = r_dwell;
    w_evt        = 1'b0;
    if (tick) begin
      case (r_state)
        Q_IDLE: begin
          if (w_present) begin
            w_state_next = Q_QUALIFY;
            w_dwell_next = '0;
          end
        end
        Q_QUALIFY: begin
          if (!w_present) begin
            w_state_next = Q_IDLE;
          end else if (r_dwell == C_DWELL_LAST) begin
            w_state_next = Q_OCCUPIED;
            w_evt        = 1'b1;
          end else begin
            w_dwell_next = r_dwell + C_DW_W'(1);
          end
        end
        Q_OCCUPIED: begin
          if (!w_present) w_state_next = Q_IDLE;
        end
        default: w_state_next = Q_IDLE;
      endcase
    end
  end

  // Queue count: a grant clears it and wins over a vehicle qualifying in the same clk
  always_comb begin
    w_queue_next = r_queue;
    if (farm_green)                       w_queue_next = '0;
    else if (w_evt && r_queue != C_CNT_MAX) w_queue_next = r_queue + COUNT_W'(1);
  end

  // Queue counter and registered request to the controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_queue   <= '0;
      r_car_req <= 1'b0;
    end else begin
      r_queue   <= w_queue_next;
      r_car_req <= !farm_green &&
                   ((w_queue_next != '0) || (w_state_next == Q_OCCUPIED));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_farm_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_farm_sensor_conditioner
//  Purpose  : Self-checking bench for farm_sensor_conditioner (default build
//             plus a COUNT_W=2 build sharing the same stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_farm_sensor_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 3;
  localparam int MIN  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       loop_raw = 1'b0;
  logic       farm_green = 1'b0;
  logic       present, vehicle_evt, car_req;
  logic [7:0] queue_cnt;
  logic       present_s, evt_s, req_s;
  logic [1:0] queue_s;

  always #5 clk = ~clk;

  farm_sensor_conditioner dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .loop_raw(loop_raw),
    .farm_green(farm_green), .present(present), .vehicle_evt(vehicle_evt),
    .car_req(car_req), .queue_cnt(queue_cnt)
  );

  farm_sensor_conditioner #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick), .loop_raw(loop_raw),
    .farm_green(farm_green), .present(present_s), .vehicle_evt(evt_s),
    .car_req(req_s), .queue_cnt(queue_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as run lengths and counts
  bit m_hist [SYNC];  // raw samples, [0] = most recent clk edge
  bit m_present;      // accepted loop level
  int m_run;          // consecutive ticks the synced level disagreed
  int m_h;            // consecutive ticks the FSM has seen present high (capped)
  int m_q8, m_q2;     // queued vehicles for each build
  bit m_req;
  bit last_ev;
  int phase = 0;
  int tick_div = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    m_present = 1'b0; m_run = 0; m_h = 0; m_q8 = 0; m_q2 = 0; m_req = 1'b0;
  endtask

  // One clk: drive at negedge, check the event strobe, advance the model, check registers
  task automatic step(input bit raw, input bit green, input bit rst_a = 1'b0,
                      input bit green_on_evt = 1'b0);
    bit tk, ev, g, loop_s;
    @(negedge clk);
    tk = (phase == 0);
    phase = (phase + 1) % tick_div;
    ev = !rst_a && tk && m_present && (m_h == MIN);
    g  = green_on_evt ? ev : green;
    rst_n = !rst_a; tick = tk; loop_raw = raw; farm_green = g;
    last_ev = ev;
    #1;
    chk("vehicle_evt", {31'd0, vehicle_evt}, {31'd0, ev});
    chk("vehicle_evt_w2", {31'd0, evt_s}, {31'd0, ev});
    if (rst_a) begin
      model_reset();
    end else begin
      loop_s = m_hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = raw;
      if (tk) begin
        if (m_present) m_h = (m_h < MIN + 1) ? m_h + 1 : m_h;
        else           m_h = 0;
        if (loop_s == m_present) m_run = 0;
        else begin
          m_run++;
          if (m_run == DEB) begin m_present = loop_s; m_run = 0; end
        end
      end
      if (g) begin
        m_q8 = 0; m_q2 = 0;
      end else if (ev) begin
        m_q8 = (m_q8 < 255) ? m_q8 + 1 : 255;
        m_q2 = (m_q2 < 3) ? m_q2 + 1 : 3;
      end
      m_req = !g && (m_q8 != 0 || m_h >= MIN + 1);
    end
    @(posedge clk);
    #1;
    chk("present", {31'd0, present}, {31'd0, m_present});
    chk("present_w2", {31'd0, present_s}, {31'd0, m_present});
    chk("car_req", {31'd0, car_req}, {31'd0, m_req});
    chk("car_req_w2", {31'd0, req_s}, {31'd0, m_req});
    chk("queue_cnt", {24'd0, queue_cnt}, m_q8);
    chk("queue_cnt_w2", {30'd0, queue_s}, m_q2);
  endtask

  task automatic hold(input bit raw, input bit green, input int n);
    repeat (n) step(raw, green);
  endtask

  initial begin
    bit seen;
    model_reset();

    // Reset with the loop occupied: everything stays cleared
    repeat (4) step(1'b1, 1'b0, 1'b1);
    chk("rst_present", {31'd0, present}, 0);
    chk("rst_car_req", {31'd0, car_req}, 0);
    chk("rst_queue", {24'd0, queue_cnt}, 0);

    // Release: car on the loop qualifies
    hold(1'b1, 1'b0, 40);
    chk("first_car_req", {31'd0, car_req}, 1);
    chk("first_queue", {24'd0, queue_cnt}, 1);
    hold(1'b0, 1'b0, 30);
    hold(1'b0, 1'b1, 2);
    chk("grant_clears", {24'd0, queue_cnt}, 0);

    // Glitch of five clks never reaches the debounced level
    hold(1'b1, 1'b0, 5);
    hold(1'b0, 1'b0, 30);
    chk("glitch_present", {31'd0, present}, 0);
    chk("glitch_queue", {24'd0, queue_cnt}, 0);
    chk("glitch_req", {31'd0, car_req}, 0);

    // Short presence
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 30);
    hold(1'b0, 1'b1, 1);

    // Three queued vehicles, then grant
    repeat (3) begin hold(1'b1, 1'b0, 40); hold(1'b0, 1'b0, 30); end
    chk("queue3", {24'd0, queue_cnt}, 3);
    chk("queue3_req", {31'd0, car_req}, 1);
    step(1'b0, 1'b1);
    chk("grant_queue0", {24'd0, queue_cnt}, 0);
    chk("grant_req0", {31'd0, car_req}, 0);
    hold(1'b0, 1'b0, 2);

    // Grant rises in the very clk a vehicle qualifies
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      seen = last_ev;
    end
    chk("simul_evt_seen", {31'd0, seen}, 1);
    chk("simul_queue", {24'd0, queue_cnt}, 0);
    chk("simul_req", {31'd0, car_req}, 0);
    hold(1'b1, 1'b1, 8);
    step(1'b1, 1'b0);
    chk("regrant_req", {31'd0, car_req}, 1);
    hold(1'b0, 1'b0, 30);
    hold(1'b0, 1'b1, 1);

    // Saturation of the narrow counter
    repeat (5) begin hold(1'b1, 1'b0, 40); hold(1'b0, 1'b0, 30); end
    chk("sat_queue_w2", {30'd0, queue_s}, 3);
    chk("sat_queue", {24'd0, queue_cnt}, 5);
    hold(1'b0, 1'b1, 1);

    // Reset pulse while qualifying
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step(1'b1, 1'b0);
      seen = (m_h == 1);
    end
    chk("mid_qualify_reached", {31'd0, seen}, 1);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_present", {31'd0, present}, 0);
    chk("midrst_req", {31'd0, car_req}, 0);
    chk("midrst_queue", {24'd0, queue_cnt}, 0);
    hold(1'b1, 1'b0, 40);
    hold(1'b0, 1'b0, 30);

    // Randomised traffic, alternating tick rates
    for (int seg = 0; seg < 6; seg++) begin
      tick_div = (seg % 2 == 0) ? 4 : 1;
      phase = 0;
      for (int n = 0; n < 400; ) begin
        int len;
        bit raw, green;
        len = $urandom_range(1, 30);
        raw = $urandom_range(0, 1);
        green = ($urandom_range(0, 9) == 0);
        for (int k = 0; k < len; k++) step(raw, green && (k < 4));
        n += len;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
